game_master_fsm_multi: RTL and testbench

- Parametrised successor of the arcade game-master controller. Sequences game start, rounds, aiming, shooting, an inter-round gap and game end for N_TARGETS targets, one spaceship and one bullet.
- Drives the per-sprite write_xy / write_dxy / enable_update strobes of the sprite engines.
- Replaces fixed heart-sprite writes with a lives-visibility mask, and adds pause, multi-hit scoring and separate win/lose results.

---
 rtl/game_master_pkg.sv | 19 +
 rtl/game_master_fsm_multi_popcount_sat.sv | 25 ++
 rtl/game_master_fsm_multi.sv | 133 +++++++++++++
 tb/tb_game_master_fsm_multi.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/game_master_pkg.sv
// Shared definitions for the arcade game-master controller: state encoding
// and default sizing of the playfield.
package game_master_pkg;

  typedef logic [2:0] state_t;

  localparam state_t START_GAME  = 3'd0;
  localparam state_t START_ROUND = 3'd1;
  localparam state_t AIM         = 3'd2;
  localparam state_t SHOOT       = 3'd3;
  localparam state_t END_ROUND   = 3'd4;
  localparam state_t ROUND_GAP   = 3'd5;
  localparam state_t END_GAME    = 3'd6;

  localparam int DEF_N_TARGETS = 3;
  localparam int DEF_MAX_LIVES = 3;
  localparam int DEF_WIN_SCORE = 3;

endpackage

// File: rtl/game_master_fsm_multi_popcount_sat.sv
// Counts the targets hit this cycle and adds them to the score, clamping at
// the largest value the score register can hold.
module popcount_sat #(
  parameter int N       = 3,
  parameter int SCORE_W = 4
) (
  input  logic [N-1:0]       hits,
  input  logic [SCORE_W-1:0] score_in,
  output logic [SCORE_W-1:0] score_out
);
  // One spare bit above the wider operand so the sum can never wrap.
  localparam int SW = ((N > SCORE_W) ? N : SCORE_W) + 1;

  logic [N-1:0]  cnt;
  logic [SW-1:0] sum;

  always_comb begin
    cnt = '0;
    for (int i = 0; i < N; i++) cnt = cnt + N'(hits[i]);
    sum = SW'(cnt) + SW'(score_in);
    if (sum > SW'({SCORE_W{1'b1}})) score_out = '1;
    else                             score_out = sum[SCORE_W-1:0];
  end

endmodule

// File: rtl/game_master_fsm_multi.sv
// Game-master sequencer for N_TARGETS targets, one spaceship and one bullet.
// Every output is a register loaded from the decode of the current state.
module game_master_fsm_multi
  import game_master_pkg::*;
#(
  parameter int N_TARGETS  = DEF_N_TARGETS,
  parameter int MAX_LIVES  = DEF_MAX_LIVES,
  parameter int WIN_SCORE  = DEF_WIN_SCORE,
  parameter int SCORE_W    = 4,
  parameter int GAP_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 launch_key,
  input  logic                 shoot,
  input  logic                 pause,
  input  logic [N_TARGETS-1:0] target_within_screen,
  input  logic                 bullet_within_screen,
  input  logic                 spaceship_within_screen,
  input  logic                 collision,
  input  logic [N_TARGETS-1:0] bullet_hit,
  input  logic                 end_of_game_timer_running,
  output logic [N_TARGETS-1:0] target_write_xy,
  output logic [N_TARGETS-1:0] target_write_dxy,
  output logic [N_TARGETS-1:0] target_enable_update,
  output logic                 bullet_write_xy,
  output logic                 bullet_write_dxy,
  output logic                 bullet_enable_update,
  output logic                 spaceship_write_xy,
  output logic                 spaceship_write_dxy,
  output logic                 spaceship_enable_update,
  output logic [MAX_LIVES-1:0] heart_visible,
  output logic                 end_of_game_timer_start,
  output logic                 game_won,
  output logic                 game_lost,
  output logic [SCORE_W-1:0]   score,
  output logic [2:0]           n_lives,
  output logic [2:0]           state_dbg
);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  state_t                 state, state_nx;
  logic [GW-1:0]          gap_cnt, gap_nx;
  logic [SCORE_W-1:0]     score_nx, score_sum;
  logic [2:0]             lives_nx;
  logic                   won_nx, lost_nx, ts_nx;
  logic [N_TARGETS-1:0]   t_wxy_nx, t_wdxy_nx, t_en_nx;
  logic                   b_wxy_nx, b_wdxy_nx, b_en_nx;
  logic                   s_wxy_nx, s_wdxy_nx, s_en_nx;
  logic [MAX_LIVES-1:0]   hv_nx;
  logic                   round_end, any_hit;

  popcount_sat #(.N(N_TARGETS), .SCORE_W(SCORE_W)) u_score (
    .hits(bullet_hit), .score_in(score), .score_out(score_sum)
  );

  assign round_end = ~&target_within_screen | ~spaceship_within_screen | ~bullet_within_screen;
  assign any_hit   = |bullet_hit;
  assign state_dbg = state;

  always_comb begin
    state_nx = state;   gap_nx  = gap_cnt;
    score_nx = score;   lives_nx = n_lives;
    won_nx   = game_won; lost_nx = game_lost; ts_nx = 1'b0;
    t_wxy_nx = '0; t_wdxy_nx = '0; t_en_nx = '0;
    b_wxy_nx = 1'b0; b_wdxy_nx = 1'b0; b_en_nx = 1'b0;
    s_wxy_nx = 1'b0; s_wdxy_nx = 1'b0; s_en_nx = 1'b0;
    case (state)
      START_GAME: begin
        score_nx = '0; lives_nx = 3'(MAX_LIVES);
        won_nx = 1'b0; lost_nx = 1'b0; ts_nx = 1'b1;
        state_nx = START_ROUND;
      end
      START_ROUND: begin
        t_wxy_nx = '1; t_wdxy_nx = '1; s_wxy_nx = 1'b1; b_wxy_nx = shoot;
        state_nx = AIM;
      end
      AIM: if (!pause) begin
        t_en_nx = '1;
        if (any_hit) begin
          score_nx = score_sum; state_nx = END_ROUND;
        end else if (launch_key) state_nx = SHOOT;
        else if (round_end)      state_nx = END_ROUND;
      end
      SHOOT: begin
        s_wdxy_nx = 1'b1; b_wdxy_nx = shoot;
        // Collision and hit in the same cycle both take effect.
        if (!pause) begin
          t_en_nx = '1; s_en_nx = 1'b1; b_en_nx = shoot;
          if (collision && n_lives != 3'd0) lives_nx = n_lives - 3'd1;
          if (any_hit) score_nx = score_sum;
          if (collision || any_hit || round_end) state_nx = END_ROUND;
        end
      end
      END_ROUND: begin
        if (n_lives == 3'd0) begin
          lost_nx = 1'b1; state_nx = END_GAME;
        end else if (score >= SCORE_W'(WIN_SCORE)) begin
          won_nx = 1'b1; state_nx = END_GAME;
        end else begin
          gap_nx = GW'(GAP_CYCLES - 1); state_nx = ROUND_GAP;
        end
      end
      // Pause freezes the countdown, so each paused cycle lengthens the gap by one.
      ROUND_GAP: if (!pause) begin
        if (gap_cnt == '0) state_nx = START_ROUND;
        else               gap_nx = gap_cnt - GW'(1);
      end
      END_GAME: if (!end_of_game_timer_running) state_nx = START_GAME;
      default: state_nx = START_GAME;
    endcase
    for (int i = 0; i < MAX_LIVES; i++) hv_nx[i] = (lives_nx > 3'(i));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= START_GAME; gap_cnt <= '0;
      score <= '0; n_lives <= 3'(MAX_LIVES); heart_visible <= '1;
      game_won <= 1'b0; game_lost <= 1'b0; end_of_game_timer_start <= 1'b0;
      target_write_xy <= '0; target_write_dxy <= '0; target_enable_update <= '0;
      bullet_write_xy <= 1'b0; bullet_write_dxy <= 1'b0; bullet_enable_update <= 1'b0;
      spaceship_write_xy <= 1'b0; spaceship_write_dxy <= 1'b0; spaceship_enable_update <= 1'b0;
    end else begin
      state <= state_nx; gap_cnt <= gap_nx;
      score <= score_nx; n_lives <= lives_nx; heart_visible <= hv_nx;
      game_won <= won_nx; game_lost <= lost_nx; end_of_game_timer_start <= ts_nx;
      target_write_xy <= t_wxy_nx; target_write_dxy <= t_wdxy_nx; target_enable_update <= t_en_nx;
      bullet_write_xy <= b_wxy_nx; bullet_write_dxy <= b_wdxy_nx; bullet_enable_update <= b_en_nx;
      spaceship_write_xy <= s_wxy_nx; spaceship_write_dxy <= s_wdxy_nx; spaceship_enable_update <= s_en_nx;
    end
  end

endmodule

// File: tb/tb_game_master_fsm_multi.sv
// Directed bench for game_master_fsm_multi at default parameters: a cycle model
// queues the expected outputs of every edge and the DUT is checked against them.
module tb_game_master_fsm_multi;
  logic clk = 1'b0, rst = 1'b1;
  logic launch_key = 0, shoot = 0, pause = 0, collision = 0;
  logic [2:0] target_within_screen = 3'b111, bullet_hit = 3'b000;
  logic bullet_within_screen = 1, spaceship_within_screen = 1, end_of_game_timer_running = 0;
  logic [2:0] target_write_xy, target_write_dxy, target_enable_update;
  logic bullet_write_xy, bullet_write_dxy, bullet_enable_update;
  logic spaceship_write_xy, spaceship_write_dxy, spaceship_enable_update;
  logic [2:0] heart_visible, n_lives, state_dbg;
  logic end_of_game_timer_start, game_won, game_lost;
  logic [3:0] score;

  always #5 clk = ~clk;

  game_master_fsm_multi dut (
    .clk(clk), .rst(rst), .launch_key(launch_key), .shoot(shoot), .pause(pause),
    .target_within_screen(target_within_screen), .bullet_within_screen(bullet_within_screen),
    .spaceship_within_screen(spaceship_within_screen), .collision(collision),
    .bullet_hit(bullet_hit), .end_of_game_timer_running(end_of_game_timer_running),
    .target_write_xy(target_write_xy), .target_write_dxy(target_write_dxy),
    .target_enable_update(target_enable_update), .bullet_write_xy(bullet_write_xy),
    .bullet_write_dxy(bullet_write_dxy), .bullet_enable_update(bullet_enable_update),
    .spaceship_write_xy(spaceship_write_xy), .spaceship_write_dxy(spaceship_write_dxy),
    .spaceship_enable_update(spaceship_enable_update), .heart_visible(heart_visible),
    .end_of_game_timer_start(end_of_game_timer_start), .game_won(game_won),
    .game_lost(game_lost), .score(score), .n_lives(n_lives), .state_dbg(state_dbg)
  );

  typedef struct packed {
    logic [2:0] txy, tdxy, ten;
    logic bxy, bdxy, ben, sxy, sdxy, sen;
    logic [2:0] hv;
    logic ts, won, lost;
    logic [3:0] score;
    logic [2:0] lives, st;
  } exp_t;

  exp_t sb_q[$];
  int vectors = 0, miscompares = 0;
  int m_st = 0, m_score = 0, m_lives = 3, m_gap = 0;
  logic m_won = 0, m_lost = 0;

  function automatic exp_t observed();
    return {target_write_xy, target_write_dxy, target_enable_update,
            bullet_write_xy, bullet_write_dxy, bullet_enable_update,
            spaceship_write_xy, spaceship_write_dxy, spaceship_enable_update,
            heart_visible, end_of_game_timer_start, game_won, game_lost,
            score, n_lives, state_dbg};
  endfunction

  task automatic chk(input string tag, input int obs, input int expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Advance the model by one edge, queue its prediction, clock the DUT, then compare.
  task automatic step();
    exp_t e, o;
    int hits, ns;
    logic re;
    e = '0;
    if (rst) begin
      m_st = 0; m_score = 0; m_lives = 3; m_gap = 0; m_won = 0; m_lost = 0;
    end else begin
      re = !(&target_within_screen) || !spaceship_within_screen || !bullet_within_screen;
      hits = $countones(bullet_hit);
      ns = m_st;
      case (m_st)
        0: begin m_score = 0; m_lives = 3; m_won = 0; m_lost = 0; e.ts = 1; ns = 1; end
        1: begin e.txy = 3'b111; e.tdxy = 3'b111; e.sxy = 1; e.bxy = shoot; ns = 2; end
        2: if (!pause) begin
             e.ten = 3'b111;
             if (hits > 0) begin m_score = (m_score + hits > 15) ? 15 : m_score + hits; ns = 4; end
             else if (launch_key) ns = 3;
             else if (re) ns = 4;
           end
        3: begin
             e.sdxy = 1; e.bdxy = shoot;
             if (!pause) begin
               e.ten = 3'b111; e.sen = 1; e.ben = shoot;
               if (collision && m_lives > 0) m_lives--;
               if (hits > 0) m_score = (m_score + hits > 15) ? 15 : m_score + hits;
               if (collision || hits > 0 || re) ns = 4;
             end
           end
        4: if (m_lives == 0) begin m_lost = 1; ns = 6; end
           else if (m_score >= 3) begin m_won = 1; ns = 6; end
           else begin m_gap = 15; ns = 5; end
        5: if (!pause) begin if (m_gap == 0) ns = 1; else m_gap--; end
        6: if (!end_of_game_timer_running) ns = 0;
        default: ns = 0;
      endcase
      m_st = ns;
    end
    e.hv = 3'((1 << m_lives) - 1);
    e.won = m_won; e.lost = m_lost;
    e.score = 4'(m_score); e.lives = 3'(m_lives); e.st = 3'(m_st);
    sb_q.push_back(e);
    @(posedge clk); #1;
    e = sb_q.pop_front();
    o = observed();
    vectors++;
    assert (o === e) else begin
      miscompares++;
      $error("FAIL cycle t=%0t: got %h expected %h", $time, o, e);
    end
  endtask

  task automatic goto_state(input logic [2:0] tgt);
    int n = 0;
    while (state_dbg !== tgt && n < 100) begin
      launch_key = (tgt == 3'd3 && state_dbg == 3'd2);
      step();
      n++;
    end
    launch_key = 0;
    chk("goto_state", int'(state_dbg), int'(tgt));
  endtask

  task automatic hit_in_aim(input logic [2:0] h);
    goto_state(3'd2);
    bullet_hit = h; step(); bullet_hit = 3'b000;
  endtask

  task automatic collide_in_shoot();
    goto_state(3'd3);
    collision = 1; step(); collision = 0;
  endtask

  initial begin
    int cnt;
    // Reset values
    step(); step();
    chk("rst_state", state_dbg, 0); chk("rst_lives", n_lives, 3);
    chk("rst_hearts", heart_visible, 7); chk("rst_score", score, 0);
    rst = 0;
    step(); chk("timer_start", end_of_game_timer_start, 1);
    step(); chk("target_write_xy", target_write_xy, 7);

    // Multi-hit scoring and gap length
    hit_in_aim(3'b101);
    chk("score_101", score, 2);
    step();
    cnt = 0;
    while (state_dbg == 3'd5 && cnt < 100) begin cnt++; step(); end
    chk("gap_len", cnt, 16);
    step(); chk("start_round_xy", target_write_xy, 7);

    // Three collisions lose the game
    end_of_game_timer_running = 1;
    collide_in_shoot(); chk("lives_2", n_lives, 2); chk("hv_011", heart_visible, 3);
    collide_in_shoot(); chk("lives_1", n_lives, 1); chk("hv_001", heart_visible, 1);
    collide_in_shoot(); chk("lives_0", n_lives, 0); chk("hv_000", heart_visible, 0);
    step(); chk("lost_state", state_dbg, 6); chk("lost", game_lost, 1); chk("not_won", game_won, 0);
    step(); step(); chk("end_hold", state_dbg, 6);
    end_of_game_timer_running = 0;
    step(); chk("back_start", state_dbg, 0);
    step(); chk("lives_reload", n_lives, 3);

    // Same-cycle collision and hit: loss outranks win
    end_of_game_timer_running = 1;
    hit_in_aim(3'b101);
    collide_in_shoot(); collide_in_shoot();
    chk("pre_score", score, 2); chk("pre_lives", n_lives, 1);
    goto_state(3'd3);
    collision = 1; bullet_hit = 3'b001; step(); collision = 0; bullet_hit = 3'b000;
    chk("both_score", score, 3); chk("both_lives", n_lives, 0);
    step(); chk("both_lost", game_lost, 1); chk("both_not_won", game_won, 0);
    end_of_game_timer_running = 0;
    goto_state(3'd0);

    // Pause in SHOOT with collision held
    goto_state(3'd3);
    pause = 1; collision = 1;
    for (int i = 0; i < 10; i++) begin
      step(); chk("pause_st", state_dbg, 3); chk("pause_en", target_enable_update, 0);
    end
    chk("pause_lives", n_lives, 3);
    pause = 0; collision = 0;
    step(); chk("resume_st", state_dbg, 3);

    // Pause stretches the round gap
    bullet_within_screen = 0; step(); bullet_within_screen = 1;
    step();
    cnt = 0;
    while (state_dbg == 3'd5 && cnt < 100) begin
      pause = (cnt >= 3 && cnt < 13);
      cnt++; step();
    end
    pause = 0;
    chk("gap_paused", cnt, 26);

    // Reset in the middle of SHOOT
    hit_in_aim(3'b101);
    goto_state(3'd3);
    chk("pre_rst_score", score, 2);
    rst = 1; #1;
    chk("async_rst_state", state_dbg, 0); chk("async_rst_score", score, 0);
    step();
    chk("rst_lives_mid", n_lives, 3); chk("rst_strobe", spaceship_write_dxy, 0);
    rst = 0;

    // Triple hit wins outright
    hit_in_aim(3'b111);
    chk("win_score", score, 3);
    step(); chk("won", game_won, 1); chk("won_not_lost", game_lost, 0);
    goto_state(3'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
